wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
- Wishbone classic single-transfer initiator. It is the master end of the same bus that the user project exposes as a slave.
- Converts a simple valid/ready request port (driven by the jacaranda-8 core or a test sequencer) into one Wishbone read or write cycle and returns a one-cycle response pulse.
- Guards every cycle with a timeout so a non-responding slave cannot hang the requester.
- Sits between the requester and any Wishbone slave port with the cyc/stb/we/sel/adr/dat/ack signal set.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8; SW = DW/8.
- TIMEOUT, 255, maximum wait cycles in BUS state before abort; 1..2^TW-1.
- TW, 8, timeout counter width.

Ports:
- wb_clk_i  input  1  single clock; all logic rising-edge.
- wb_rst_ni  input  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  bridge can accept a request.
- req_we_i  input  1  1=write, 0=read.
- req_adr_i  input  AW  byte address.
- req_dat_i  input  DW  write data.
- req_sel_i  input  SW  byte lanes.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_dat_o  output  DW  read data; 0 for writes and errors.
- rsp_err_o  output  1  qualified by rsp_valid_o; bus error or timeout.
- rsp_tmo_o  output  1  qualified by rsp_valid_o; timeout (implies rsp_err_o).
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  SW  Wishbone byte select.
- wbm_adr_o  output  AW  Wishbone address.
- wbm_dat_o  output  DW  Wishbone write data.
- wbm_dat_i  input  DW  Wishbone read data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- wbm_err_i  input  1  Wishbone error; tie 0 if unused.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (wb_rst_ni=0, async): state=IDLE; all outputs 0 except req_ready_o=1; timeout counter=0.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On an edge with req_valid_i=1: register we/adr/dat/sel onto the wbm_* outputs, clear counter, go to BUS.
  - Request fields are sampled only at acceptance; later changes have no effect.
- BUS:
  - wbm_cyc_o=wbm_stb_o=1; wbm_we/sel/adr/dat held stable; req_ready_o=0.
  - Each cycle without ack/err increments the counter.
  - Edge with wbm_err_i=1: go to RESP; rsp_err=1, rsp_dat=0. Error wins over a simultaneous ack.
  - Else edge with wbm_ack_i=1: go to RESP; rsp_dat = wbm_dat_i if read, else 0; rsp_err=0.
  - Else counter == TIMEOUT: go to RESP; rsp_err=1, rsp_tmo=1, rsp_dat=0.
  - Leaving BUS deasserts cyc/stb on the same edge. No cycle is ever longer than TIMEOUT+1 clocks.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_dat/err/tmo are valid in that cycle; go to IDLE next edge.
  - Outside RESP, rsp_valid_o=0 and rsp_err/rsp_tmo=0. rsp_dat_o holds its last value.
- Latency:
  - Accept edge → cyc/stb high next cycle.
  - A slave acking in its first strobe cycle yields rsp_valid_o 2 cycles after the accept edge.
  - Minimum request-to-request spacing is 3 cycles; no pipelining, single outstanding transfer.
- wbm_we/sel/adr/dat_o keep their last values in IDLE; only cyc/stb qualify them.
- Reset mid-cycle: cyc/stb drop immediately (async), and no response is issued for the aborted transfer.
- A late ack arriving after a timeout, or in IDLE, is ignored.

Test Plan:
- Write, slave acks first strobe cycle: req adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF, we=1 → cyc/stb high 1 cycle with those values; rsp_valid pulse 2 cycles after accept, rsp_err=0, rsp_dat=0.
- Read with 3 wait states: slave returns 0x0000_00A5 on 4th strobe cycle → rsp_dat=0x000000A5, rsp_err=0; req_ready=0 throughout; cyc high exactly 4 cycles.
- Timeout with TIMEOUT=4 and slave silent → cyc high 5 cycles, then rsp_valid with rsp_err=1, rsp_tmo=1, rsp_dat=0; a later stray ack in IDLE produces no response.
- Error: wbm_err_i and wbm_ack_i both asserted on the same edge → rsp_err=1, rsp_tmo=0, rsp_dat=0.
- Reset mid-operation: drop wb_rst_ni during BUS → cyc/stb fall without waiting for a clock edge, no rsp_valid; after release, req_ready=1 and the next read completes normally.
- Back-to-back: req_valid held high with two queued requests (write, then read, sel=0x1) → second accepted in the IDLE cycle after RESP; acceptance edges exactly 3 cycles apart with zero-wait slave; sel=0x1 seen on the bus.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator.
// Turns one valid/ready request into one Wishbone read or write cycle and
// returns a one-cycle response pulse. A timeout aborts the cycle if the slave
// never answers.
//
//   state | meaning
//   IDLE  | ready for a request; bus outputs keep their last values
//   BUS   | cyc/stb asserted, waiting for ack, err or timeout
//   RESP  | rsp_valid_o high for one cycle, then back to IDLE
module wb_master_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8,
  localparam int SW     = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [DW-1:0] req_dat_i,
  input  logic [SW-1:0] req_sel_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          rsp_tmo_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [SW-1:0] wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  logic [1:0]    state;
  logic [TW-1:0] tmo_cnt;

  // Handshake and bus strobes decode straight from the state register, so an
  // async reset drops cyc/stb immediately and raises req_ready_o.
  always_comb begin
    req_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
    wbm_cyc_o   = (state == BUS);
    wbm_stb_o   = (state == BUS);
    rsp_valid_o = (state == RESP);
  end

  // Request capture, cycle termination and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
      rsp_tmo_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wbm_we_o  <= req_we_i;
            wbm_sel_o <= req_sel_i;
            wbm_adr_o <= req_adr_i;
            wbm_dat_o <= req_dat_i;
            tmo_cnt   <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Error takes priority over a simultaneous ack.
          if (wbm_err_i) begin
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b1;
            rsp_tmo_o <= 1'b0;
            state     <= RESP;
          end else if (wbm_ack_i) begin
            rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o <= 1'b0;
            rsp_tmo_o <= 1'b0;
            state     <= RESP;
          end else if (tmo_cnt == TMO_LIMIT) begin
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b1;
            rsp_tmo_o <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          // err/tmo are only meaningful alongside rsp_valid_o; rsp_dat_o holds.
          rsp_err_o <= 1'b0;
          rsp_tmo_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with TIMEOUT=4.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, err, busy;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int rsp_cnt = 0;
  int edge_no = 0;
  int acc_q[$];

  wb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(4), .TW(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_tmo_o(rsp_tmo),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Count strobe cycles and response pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc) cyc_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  // Log the edge number of every accepted request.
  always @(posedge clk) begin
    edge_no++;
    if (rst_n && req_valid && req_ready) acc_q.push_back(edge_no);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
    req_dat = '0; req_sel = '0; dat_i = '0; ack = 1'b0; err = 1'b0;
    #1;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_cyc", cyc, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_adr", adr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Write, slave acks in the first strobe cycle.
    cyc_cnt = 0; rsp_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0004;
    req_dat = 32'hDEAD_BEEF; req_sel = 4'hF;
    step();
    chk1("wr_cyc", cyc, 1'b1);
    chk1("wr_stb", stb, 1'b1);
    chk1("wr_we", we, 1'b1);
    chk32("wr_adr", adr, 32'h3000_0004);
    chk32("wr_dat", dat_o, 32'hDEAD_BEEF);
    chk32("wr_sel", 32'(sel), 32'hF);
    chk1("wr_ready_bus", req_ready, 1'b0);
    req_valid = 1'b0; req_adr = 32'h1111_1111; ack = 1'b1; dat_i = 32'h5555_5555;
    step();
    chk1("wr_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_rsp_err", rsp_err, 1'b0);
    chk32("wr_rsp_dat", rsp_dat, 32'h0);
    chk1("wr_cyc_drop", cyc, 1'b0);
    ack = 1'b0;
    step();
    chk1("wr_rsp_once", rsp_valid, 1'b0);
    chk1("wr_ready_idle", req_ready, 1'b1);
    chk32("wr_adr_held", adr, 32'h3000_0004);
    chk32("wr_cyc_len", 32'(cyc_cnt), 32'd1);

    // Read with three wait states.
    cyc_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0008; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("rd_wait_cyc", cyc, 1'b1);
      chk1("rd_wait_ready", req_ready, 1'b0);
      chk1("rd_wait_rsp", rsp_valid, 1'b0);
      step();
    end
    chk1("rd_cyc4", cyc, 1'b1);
    chk1("rd_we", we, 1'b0);
    ack = 1'b1; dat_i = 32'h0000_00A5;
    step();
    ack = 1'b0; dat_i = 32'h0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rsp_dat", rsp_dat, 32'h0000_00A5);
    chk1("rd_rsp_err", rsp_err, 1'b0);
    step();
    chk32("rd_cyc_len", 32'(cyc_cnt), 32'd4);
    chk32("rd_dat_hold", rsp_dat, 32'h0000_00A5);

    // Timeout with a silent slave.
    cyc_cnt = 0; rsp_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0010;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk1("tmo_cyc5", cyc, 1'b1);
    chk1("tmo_no_rsp_yet", rsp_valid, 1'b0);
    step();
    chk1("tmo_rsp_valid", rsp_valid, 1'b1);
    chk1("tmo_rsp_err", rsp_err, 1'b1);
    chk1("tmo_rsp_tmo", rsp_tmo, 1'b1);
    chk32("tmo_rsp_dat", rsp_dat, 32'h0);
    chk1("tmo_cyc_drop", cyc, 1'b0);
    step();
    chk1("tmo_err_clear", rsp_err, 1'b0);
    chk1("tmo_tmo_clear", rsp_tmo, 1'b0);
    ack = 1'b1; dat_i = 32'hBAD0_BAD0;
    step();
    ack = 1'b0;
    step();
    chk32("tmo_cyc_len", 32'(cyc_cnt), 32'd5);
    chk32("stray_ack_rsp", 32'(rsp_cnt), 32'd1);
    chk1("stray_ack_busy", busy, 1'b0);

    // Error and ack on the same edge.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020;
    step();
    req_valid = 1'b0; ack = 1'b1; err = 1'b1; dat_i = 32'h1234_5678;
    step();
    ack = 1'b0; err = 1'b0;
    chk1("err_rsp_valid", rsp_valid, 1'b1);
    chk1("err_rsp_err", rsp_err, 1'b1);
    chk1("err_rsp_tmo", rsp_tmo, 1'b0);
    chk32("err_rsp_dat", rsp_dat, 32'h0);
    step();

    // Reset in the middle of a bus cycle.
    rsp_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0030;
    step();
    req_valid = 1'b0;
    chk1("mid_cyc_before", cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_cyc_async", cyc, 1'b0);
    chk1("mid_stb_async", stb, 1'b0);
    chk1("mid_ready_async", req_ready, 1'b1);
    ack = 1'b1; dat_i = 32'hFFFF_0000;
    step();
    ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk32("mid_no_rsp", 32'(rsp_cnt), 32'd0);
    chk1("mid_ready_after", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0040;
    step();
    req_valid = 1'b0; ack = 1'b1; dat_i = 32'hCAFE_0001;
    chk32("mid_next_adr", adr, 32'h3000_0040);
    step();
    ack = 1'b0;
    chk1("mid_next_valid", rsp_valid, 1'b1);
    chk32("mid_next_dat", rsp_dat, 32'hCAFE_0001);
    step();

    // Back-to-back requests with req_valid held and a zero-wait slave.
    acc_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h0000_0040;
    req_dat = 32'h0000_0011; req_sel = 4'hF;
    step();
    chk1("b2b_we1", we, 1'b1);
    chk32("b2b_adr1", adr, 32'h0000_0040);
    req_we = 1'b0; req_adr = 32'h0000_0044; req_sel = 4'h1;
    ack = 1'b1; dat_i = 32'h0000_0077;
    step();
    chk1("b2b_rsp1", rsp_valid, 1'b1);
    chk32("b2b_rsp1_dat", rsp_dat, 32'h0);
    step();
    chk1("b2b_idle_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    chk1("b2b_cyc2", cyc, 1'b1);
    chk32("b2b_sel2", 32'(sel), 32'h1);
    chk32("b2b_adr2", adr, 32'h0000_0044);
    chk1("b2b_we2", we, 1'b0);
    step();
    ack = 1'b0;
    chk1("b2b_rsp2", rsp_valid, 1'b1);
    chk32("b2b_rsp2_dat", rsp_dat, 32'h0000_0077);
    step();
    chk32("b2b_accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2)
      chk32("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
